cnn_layer_accel_job_ctrl: RTL and testbench

CNN_LAYER_ACCEL_JOB_CTRL -- requirements
Module: cnn_layer_accel_job_ctrl

---
 rtl/cnn_layer_accel_job_ctrl_pkg.sv | 31 +++
 rtl/cnn_layer_accel_job_ctrl_job_desc_fifo.sv | 85 ++++++++
 rtl/cnn_layer_accel_job_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_cnn_layer_accel_job_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_job_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_layer_accel_job_ctrl_pkg
// Description : Shared accelerator definitions for the CNN layer job
//               controller: descriptor width, counter width and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_layer_accel_job_ctrl_pkg;

  // Job descriptor width (quad job_parameters format)
  localparam int C_DESC_W      = 128;
  // Completed-job counter width
  localparam int C_JOBS_DONE_W = 16;

  // Job controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_FETCH      = 3'd3,
    ST_RUN        = 3'd4,
    ST_ACK        = 3'd5
  } job_state_e;

  // States during which the watchdog is counting
  function automatic logic in_watch_state(input job_state_e s);
    return (s == ST_FETCH) || (s == ST_RUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_layer_accel_job_ctrl_job_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : job_desc_fifo
// Description : Synchronous descriptor FIFO with registered storage, full /
//               empty flags and a registered ready that rises one cycle
//               after reset is released.
// Revision    : 1.0 - initial release
// ============================================================================
module job_desc_fifo #(
  parameter int C_DEPTH = 4,
  parameter int C_WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [C_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic [C_WIDTH-1:0] head_data,
  output logic               full,
  output logic               empty,
  output logic               ready
);

  localparam int               C_AW       = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
  localparam logic [C_AW:0]    C_FULL_CNT = (C_AW + 1)'(C_DEPTH);

  logic [C_WIDTH-1:0] mem_q [C_DEPTH];
  logic [C_WIDTH-1:0] mem_d [C_DEPTH];
  logic [C_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [C_AW:0]      count_q, count_d;
  logic               ready_q, ready_d;
  logic               do_push;
  logic               do_pop;

  assign full      = (count_q == C_FULL_CNT);
  assign empty     = (count_q == '0);
  assign ready     = ready_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers, occupancy and ready flag
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Ready tracks the occupancy after this cycle's push/pop
    ready_d = (count_d != C_FULL_CNT);
  end

  // FIFO state registers, emptied on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_layer_accel_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnn_layer_accel_job_ctrl
// Description : Queues host job descriptors and sequences each job through
//               the quad handshake (start, fetch, run, acknowledge) with a
//               watchdog on the fetch/run phases.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_job_ctrl_pkg::*;
#(
  parameter int C_JOB_FIFO_DEPTH = 4,
  parameter int C_TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_if,
  input  logic                     rst,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [C_DESC_W-1:0]      desc_data,
  output logic                     job_start,
  input  logic                     job_accept,
  output logic [C_DESC_W-1:0]      job_parameters,
  output logic                     job_parameters_valid,
  input  logic                     job_fetch_request,
  output logic                     job_fetch_ack,
  input  logic                     job_fetch_complete,
  input  logic                     job_complete,
  output logic                     job_complete_ack,
  output logic                     busy,
  output logic [C_JOBS_DONE_W-1:0] jobs_done,
  output logic                     timeout_err
);

  // A limit of zero turns the watchdog off entirely
  localparam bit          C_WD_EN    = (C_TIMEOUT_CYCLES != 0);
  localparam logic [31:0] C_WD_LIMIT = (C_TIMEOUT_CYCLES == 0) ? 32'd0
                                                               : 32'(C_TIMEOUT_CYCLES - 1);

  job_state_e               state_q, state_d;
  logic [C_DESC_W-1:0]      param_q, param_d;
  logic                     job_start_q, job_start_d;
  logic                     fetch_ack_q, fetch_ack_d;
  logic                     complete_ack_q, complete_ack_d;
  logic [C_JOBS_DONE_W-1:0] jobs_done_q, jobs_done_d;
  logic                     timeout_err_q, timeout_err_d;
  logic [31:0]              wd_q, wd_d;
  logic                     wd_hit;
  logic                     wd_fire;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic [C_DESC_W-1:0]      fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_ready;

  assign fifo_push = desc_valid && fifo_ready && !fifo_full;
  assign wd_hit    = C_WD_EN && (wd_q == C_WD_LIMIT);

  job_desc_fifo #(
    .C_DEPTH (C_JOB_FIFO_DEPTH),
    .C_WIDTH (C_DESC_W)
  ) u_job_desc_fifo (
    .clk       (clk_if),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (desc_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ready     (fifo_ready)
  );

  // FSM state register
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; the watchdog only forces ACK when the quad has
  // not already finished in the same cycle
  always_comb begin
    state_d = state_q;
    wd_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (job_accept) begin
          state_d = ST_FETCH_WAIT;
        end
      end
      ST_FETCH_WAIT: begin
        if (job_fetch_request) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (job_fetch_complete && job_complete) begin
          state_d = ST_ACK;
        end else if (job_fetch_complete) begin
          state_d = ST_RUN;
        end else if (wd_hit) begin
          state_d = ST_ACK;
          wd_fire = 1'b1;
        end
      end
      ST_RUN: begin
        if (job_complete) begin
          state_d = ST_ACK;
        end else if (wd_hit) begin
          state_d = ST_ACK;
          wd_fire = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs and datapath next values, registered from the next state
  always_comb begin
    fifo_pop       = (state_q == ST_IDLE) && !fifo_empty;
    param_d        = fifo_pop ? fifo_head : param_q;
    job_start_d    = (state_d == ST_START);
    fetch_ack_d    = (state_q == ST_FETCH_WAIT) && (state_d == ST_FETCH);
    complete_ack_d = (state_d == ST_ACK);
    jobs_done_d    = complete_ack_d ? (jobs_done_q + 1'b1) : jobs_done_q;
    timeout_err_d  = timeout_err_q | wd_fire;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (C_WD_EN && in_watch_state(state_q)) begin
      wd_d = wd_q + 32'd1;
    end else begin
      wd_d = wd_q;
    end
  end

  // Output, counter and watchdog registers
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      param_q        <= '0;
      job_start_q    <= 1'b0;
      fetch_ack_q    <= 1'b0;
      complete_ack_q <= 1'b0;
      jobs_done_q    <= '0;
      timeout_err_q  <= 1'b0;
      wd_q           <= '0;
    end else begin
      param_q        <= param_d;
      job_start_q    <= job_start_d;
      fetch_ack_q    <= fetch_ack_d;
      complete_ack_q <= complete_ack_d;
      jobs_done_q    <= jobs_done_d;
      timeout_err_q  <= timeout_err_d;
      wd_q           <= wd_d;
    end
  end

  assign desc_ready           = fifo_ready;
  assign job_start            = job_start_q;
  assign job_parameters_valid = job_start_q;
  assign job_parameters       = param_q;
  assign job_fetch_ack        = fetch_ack_q;
  assign job_complete_ack     = complete_ack_q;
  assign busy                 = (state_q != ST_IDLE);
  assign jobs_done            = jobs_done_q;
  assign timeout_err          = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_layer_accel_job_ctrl
// Description : Directed self-checking bench for the CNN layer job controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_layer_accel_job_ctrl;

  logic         clk_if = 1'b0;
  logic         rst;
  logic         desc_valid;
  logic         desc_ready;
  logic [127:0] desc_data;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_parameters_valid;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;
  logic         busy;
  logic [15:0]  jobs_done;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int n_start = 0;
  int n_fack = 0;
  int n_cack = 0;
  logic start_prev = 1'b0;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_ctrl #(
    .C_JOB_FIFO_DEPTH (4),
    .C_TIMEOUT_CYCLES (16)
  ) dut (
    .clk_if               (clk_if),
    .rst                  (rst),
    .desc_valid           (desc_valid),
    .desc_ready           (desc_ready),
    .desc_data            (desc_data),
    .job_start            (job_start),
    .job_accept           (job_accept),
    .job_parameters       (job_parameters),
    .job_parameters_valid (job_parameters_valid),
    .job_fetch_request    (job_fetch_request),
    .job_fetch_ack        (job_fetch_ack),
    .job_fetch_complete   (job_fetch_complete),
    .job_complete         (job_complete),
    .job_complete_ack     (job_complete_ack),
    .busy                 (busy),
    .jobs_done            (jobs_done),
    .timeout_err          (timeout_err)
  );

  // Pulse / window counters, sampled on the rising edge before updates land
  always @(posedge clk_if) begin
    if (job_start === 1'b1 && start_prev !== 1'b1) n_start++;
    if (job_fetch_ack === 1'b1) n_fack++;
    if (job_complete_ack === 1'b1) n_cack++;
    start_prev = job_start;
  end

  task automatic tick();
    @(negedge clk_if);
  endtask

  task automatic push_desc(input logic [127:0] d);
    int n;
    n = 0;
    while (desc_ready !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: desc_ready=%b, required 1", desc_ready);
    end
    desc_valid = 1'b1;
    desc_data  = d;
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_job_start(input logic [127:0] exp);
    int n;
    n = 0;
    while (job_start !== 1'b1 && n < 60) begin tick(); n++; end
    checks++;
    if (job_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_job_start: job_start=%b after %0d cycles, required 1", job_start, n);
    end
    checks++;
    if (job_parameters !== exp || job_parameters_valid !== 1'b1) begin
      errors++;
      $display("FAIL job_params: params=%h valid=%b, required params=%h valid=1",
               job_parameters, job_parameters_valid, exp);
    end
  endtask

  task automatic do_accept(input logic [127:0] exp, input int dly);
    for (int i = 0; i < dly; i++) tick();
    checks++;
    if (job_start !== 1'b1 || job_parameters_valid !== 1'b1 || job_parameters !== exp) begin
      errors++;
      $display("FAIL start_hold: start=%b valid=%b params=%h, required 1 1 %h",
               job_start, job_parameters_valid, job_parameters, exp);
    end
    job_accept = 1'b1;
    tick();
    job_accept = 1'b0;
    checks++;
    if (job_start !== 1'b0 || job_parameters_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_drop: start=%b valid=%b, required 0 0", job_start, job_parameters_valid);
    end
  endtask

  task automatic do_fetch(input int dly);
    for (int i = 0; i < dly; i++) tick();
    checks++;
    if (job_fetch_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack_early: fetch_ack=%b, required 0", job_fetch_ack);
    end
    job_fetch_request = 1'b1;
    tick();
    checks++;
    if (job_fetch_ack !== 1'b1) begin
      errors++;
      $display("FAIL fetch_ack: fetch_ack=%b, required 1", job_fetch_ack);
    end
    tick();
    job_fetch_request = 1'b0;
    checks++;
    if (job_fetch_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack_width: fetch_ack=%b in FETCH, required 0", job_fetch_ack);
    end
  endtask

  task automatic finish_job(input int fcd, input int cd, input bit simul);
    for (int i = 0; i < fcd; i++) tick();
    if (simul) begin
      job_fetch_complete = 1'b1;
      job_complete       = 1'b1;
      tick();
      job_fetch_complete = 1'b0;
      job_complete       = 1'b0;
    end else begin
      job_fetch_complete = 1'b1;
      tick();
      job_fetch_complete = 1'b0;
      for (int i = 1; i < cd; i++) tick();
      job_complete = 1'b1;
      tick();
      job_complete = 1'b0;
    end
    checks++;
    if (job_complete_ack !== 1'b1) begin
      errors++;
      $display("FAIL complete_ack: complete_ack=%b, required 1", job_complete_ack);
    end
    exp_done++;
    checks++;
    if (jobs_done !== 16'(exp_done)) begin
      errors++;
      $display("FAIL jobs_done: jobs_done=%0d, required %0d", jobs_done, exp_done);
    end
    tick();
    checks++;
    if (job_complete_ack !== 1'b0) begin
      errors++;
      $display("FAIL complete_ack_width: complete_ack=%b, required 0", job_complete_ack);
    end
  endtask

  task automatic serve_job(input logic [127:0] exp, input int acc, input int fd,
                           input int fcd, input int cd, input bit simul);
    wait_job_start(exp);
    do_accept(exp, acc);
    do_fetch(fd);
    finish_job(fcd, cd, simul);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({job_start, job_parameters_valid, job_fetch_ack, job_complete_ack, busy,
         timeout_err, desc_ready} !== 7'b0 || jobs_done !== 16'd0 || job_parameters !== 128'd0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b pv=%b fack=%b cack=%b busy=%b to=%b rdy=%b done=%0d, required all 0",
               job_start, job_parameters_valid, job_fetch_ack, job_complete_ack, busy,
               timeout_err, desc_ready, jobs_done);
    end
    rst = 1'b0;
    checks++;
    if (desc_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early: desc_ready=%b, required 0", desc_ready);
    end
    tick();
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: desc_ready=%b, required 1", desc_ready);
    end
  endtask

  task automatic test_single_job();
    int s0, f0, c0;
    logic [127:0] d;
    s0 = n_start; f0 = n_fack; c0 = n_cack;
    d  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;
    push_desc(d);
    serve_job(d, 3, 2, 5, 10, 1'b0);
    repeat (3) tick();
    checks++;
    if (n_start - s0 != 1 || n_fack - f0 != 1 || n_cack - c0 != 1) begin
      errors++;
      $display("FAIL single_counts: starts=%0d fetch_acks=%0d complete_acks=%0d, required 1 1 1",
               n_start - s0, n_fack - f0, n_cack - c0);
    end
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b timeout_err=%b, required 0 0", busy, timeout_err);
    end
  endtask

  task automatic test_fifo_full();
    logic [127:0] d [5];
    for (int i = 0; i < 5; i++) d[i] = {96'hF1F0_0000_0000_0000_0000_0000, 32'(i + 16)};
    for (int i = 0; i < 5; i++) push_desc(d[i]);
    checks++;
    if (desc_ready !== 1'b0 || job_start !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full: desc_ready=%b job_start=%b, required 0 1", desc_ready, job_start);
    end
    desc_valid = 1'b1;
    desc_data  = 128'hDEAD;
    repeat (3) tick();
    desc_valid = 1'b0;
    for (int i = 0; i < 5; i++) serve_job(d[i], 1, 1, 1, 2, 1'b0);
    repeat (4) tick();
    checks++;
    if (job_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fifo_overflow: job_start=%b busy=%b, required 0 0", job_start, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [3];
    for (int i = 0; i < 3; i++) d[i] = {64'hB2B0_0000_0000_0000, 64'(i * 7 + 3)};
    for (int i = 0; i < 3; i++) push_desc(d[i]);
    for (int i = 0; i < 3; i++) begin
      serve_job(d[i], 0, 0, 0, 1, 1'b0);
      if (i < 2) begin
        checks++;
        if (job_start !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap: job_start=%b one cycle after ack, required 0", job_start);
        end
        tick();
        checks++;
        if (job_start !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart: job_start=%b two cycles after ack, required 1", job_start);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int c0;
    logic [127:0] d;
    d  = 128'h5151_0000_0000_0000_0000_0000_0000_0042;
    c0 = n_cack;
    push_desc(d);
    serve_job(d, 1, 1, 2, 0, 1'b1);
    repeat (3) tick();
    checks++;
    if (n_cack - c0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_ack: complete_acks=%0d busy=%b, required 1 0", n_cack - c0, busy);
    end
  endtask

  task automatic test_watchdog();
    int n;
    logic [127:0] d;
    d = 128'h7777_0000_0000_0000_0000_0000_0000_0016;
    push_desc(d);
    wait_job_start(d);
    do_accept(d, 1);
    do_fetch(0);
    job_fetch_complete = 1'b1;
    tick();
    job_fetch_complete = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_run_entry: timeout_err=%b busy=%b, required 0 1", timeout_err, busy);
    end
    n = 0;
    while (job_complete_ack !== 1'b1 && n < 40) begin tick(); n++; end
    exp_done++;
    checks++;
    if (n != 16 || job_complete_ack !== 1'b1) begin
      errors++;
      $display("FAIL wd_latency: ack after %0d cycles (ack=%b), required 16", n, job_complete_ack);
    end
    checks++;
    if (timeout_err !== 1'b1 || jobs_done !== 16'(exp_done)) begin
      errors++;
      $display("FAIL wd_error: timeout_err=%b jobs_done=%0d, required 1 %0d", timeout_err, jobs_done, exp_done);
    end
    repeat (2) tick();
    checks++;
    if (timeout_err !== 1'b1 || job_complete_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_sticky: timeout_err=%b cack=%b busy=%b, required 1 0 0", timeout_err, job_complete_ack, busy);
    end
  endtask

  task automatic test_reset_in_run();
    int c0;
    logic [127:0] d;
    logic [127:0] d2;
    d  = 128'hAAAA_0000_0000_0000_0000_0000_0000_0001;
    d2 = 128'hBBBB_0000_0000_0000_0000_0000_0000_0002;
    push_desc(d);
    wait_job_start(d);
    do_accept(d, 1);
    do_fetch(1);
    job_fetch_complete = 1'b1;
    tick();
    job_fetch_complete = 1'b0;
    repeat (3) tick();
    c0  = n_cack;
    rst = 1'b1;
    #1;
    checks++;
    if ({job_start, job_parameters_valid, job_fetch_ack, job_complete_ack, busy,
         timeout_err, desc_ready} !== 7'b0 || jobs_done !== 16'd0 || job_parameters !== 128'd0) begin
      errors++;
      $display("FAIL rst_run_outputs: start=%b pv=%b fack=%b cack=%b busy=%b to=%b rdy=%b done=%0d, required all 0",
               job_start, job_parameters_valid, job_fetch_ack, job_complete_ack, busy,
               timeout_err, desc_ready, jobs_done);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (n_cack != c0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_abandon: complete_acks=%0d busy=%b, required 0 0", n_cack - c0, busy);
    end
    exp_done = 0;
    push_desc(d2);
    serve_job(d2, 2, 1, 1, 3, 1'b0);
  endtask

  initial begin
    rst                = 1'b1;
    desc_valid         = 1'b0;
    desc_data          = '0;
    job_accept         = 1'b0;
    job_fetch_request  = 1'b0;
    job_fetch_complete = 1'b0;
    job_complete       = 1'b0;
    test_reset();
    test_single_job();
    test_fifo_full();
    test_back_to_back();
    test_simultaneous();
    test_watchdog();
    test_reset_in_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
